// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the pair-mux scheduler: select codes, FSM state
// and the select-code -> source-mask helper.
package mux_sched_pkg;

    localparam logic [1:0] SE_AB = 2'b00;
    localparam logic [1:0] SE_BC = 2'b01;
    localparam logic [1:0] SE_CD = 2'b10;
    localparam logic [1:0] SE_AD = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Returns the consumed sources as {D,C,B,A}.
    function automatic logic [3:0] pair_mask(input logic [1:0] se);
        logic [3:0] mask;
        case (se)
            SE_AB:   mask = 4'b0011;
            SE_BC:   mask = 4'b0110;
            SE_CD:   mask = 4'b1100;
            default: mask = 4'b1001;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/rr_pair_picker.sv
// Combinational round-robin picker: first eligible pair code searching from
// i_ptr upward, modulo 4.
module rr_pair_picker (
    input  logic [3:0] i_eligible,
    input  logic [1:0] i_ptr,
    output logic       o_grant_valid,
    output logic [1:0] o_grant
);

    logic [1:0] w_idx;

    // Walk from lowest priority to highest so the highest-priority hit wins.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant       = i_ptr;
        w_idx         = i_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_eligible[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant       = w_idx;
            end
        end
    end

endmodule

// File: rtl/mux_pair_scheduler.sv
// Round-robin scheduler feeding the 4-in/2-out pair mux from sources A..D.
// Optional per-pair grant counters are enabled with MUX_SCHED_STATS_EN.
module mux_pair_scheduler
    import mux_sched_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic [DATA_W-1:0] c_data,
    input  logic [DATA_W-1:0] d_data,
    input  logic              a_valid,
    input  logic              b_valid,
    input  logic              c_valid,
    input  logic              d_valid,
    output logic              a_ready,
    output logic              b_ready,
    output logic              c_ready,
    output logic              d_ready,
    output logic [DATA_W-1:0] out_m,
    output logic [DATA_W-1:0] out_n,
    output logic [1:0]        out_se,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MUX_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_ab,
    output logic [CNT_W-1:0]  stat_bc,
    output logic [CNT_W-1:0]  stat_cd,
    output logic [CNT_W-1:0]  stat_ad
`endif
);

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [DATA_W-1:0] r_m;
    logic [DATA_W-1:0] r_n;
    logic [1:0]        r_se;

    logic [3:0]        w_eligible;
    logic              w_grant_valid;
    logic [1:0]        w_grant;
    logic              w_load_en;
    logic              w_fire;
    logic [3:0]        w_ready;
    logic [DATA_W-1:0] w_m;
    logic [DATA_W-1:0] w_n;

    // Eligibility is indexed by pair code.
    assign w_eligible[SE_AB] = a_valid & b_valid;
    assign w_eligible[SE_BC] = b_valid & c_valid;
    assign w_eligible[SE_CD] = c_valid & d_valid;
    assign w_eligible[SE_AD] = a_valid & d_valid;

    rr_pair_picker u_picker (
        .i_eligible    (w_eligible),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant       (w_grant)
    );

    assign w_load_en = (r_state == EMPTY) || out_ready;
    assign w_fire    = w_load_en && w_grant_valid && !rst;
    assign w_ready   = w_fire ? pair_mask(w_grant) : 4'b0000;

    assign a_ready = w_ready[0];
    assign b_ready = w_ready[1];
    assign c_ready = w_ready[2];
    assign d_ready = w_ready[3];

    always_comb begin
        w_m = a_data;
        w_n = b_data;
        case (w_grant)
            SE_AB: begin w_m = a_data; w_n = b_data; end
            SE_BC: begin w_m = b_data; w_n = c_data; end
            SE_CD: begin w_m = c_data; w_n = d_data; end
            default: begin w_m = a_data; w_n = d_data; end
        endcase
    end

    // Unload and reload share the same edge, so a steady stream has no bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_ptr   <= SE_AB;
            r_m     <= '0;
            r_n     <= '0;
            r_se    <= SE_AB;
        end else if (w_load_en) begin
            if (w_grant_valid) begin
                r_state <= FULL;
                r_ptr   <= w_grant + 2'd1;
                r_m     <= w_m;
                r_n     <= w_n;
                r_se    <= w_grant;
            end else begin
                r_state <= EMPTY;
            end
        end
    end

    assign out_m     = r_m;
    assign out_n     = r_n;
    assign out_se    = r_se;
    assign out_valid = (r_state == FULL);

`ifdef MUX_SCHED_STATS_EN
    logic [3:0][CNT_W-1:0] r_cnt;

    // Saturating counters, one per pair code.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_fire && (r_cnt[w_grant] != {CNT_W{1'b1}})) begin
            r_cnt[w_grant] <= r_cnt[w_grant] + 1'b1;
        end
    end

    assign stat_ab = r_cnt[SE_AB];
    assign stat_bc = r_cnt[SE_BC];
    assign stat_cd = r_cnt[SE_CD];
    assign stat_ad = r_cnt[SE_AD];
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_pair_scheduler.sv
// Directed table-driven bench for mux_pair_scheduler; counter checks run only
// when MUX_SCHED_STATS_EN is defined.
module tb_mux_pair_scheduler;

`ifdef MUX_SCHED_STATS_EN
    localparam int CNT_W = 3;
`else
    localparam int CNT_W = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a_data, b_data, c_data, d_data;
    logic       a_valid, b_valid, c_valid, d_valid;
    logic       a_ready, b_ready, c_ready, d_ready;
    logic [3:0] out_m, out_n;
    logic [1:0] out_se;
    logic       out_valid;
    logic       out_ready;
`ifdef MUX_SCHED_STATS_EN
    logic [CNT_W-1:0] stat_ab, stat_bc, stat_cd, stat_ad;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_pair_scheduler #(.DATA_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .b_data(b_data), .c_data(c_data), .d_data(d_data),
        .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
        .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
        .out_m(out_m), .out_n(out_n), .out_se(out_se), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_SCHED_STATS_EN
        , .stat_ab(stat_ab), .stat_bc(stat_bc), .stat_cd(stat_cd), .stat_ad(stat_ad)
`endif
    );

    // vld/rdy are {D,C,B,A}; rdy is checked before the edge, the rest after it.
    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] a, b, c, d;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] se;
        logic [3:0] m, n;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        rst = v.rst;
        {d_valid, c_valid, b_valid, a_valid} = v.vld;
        a_data = v.a; b_data = v.b; c_data = v.c; d_data = v.d;
        out_ready = v.ordy;
        #1;
        chk($sformatf("ready[%0d]", idx), {d_ready, c_ready, b_ready, a_ready}, v.rdy);
        @(posedge clk);
        #1;
        chk($sformatf("out_valid[%0d]", idx), out_valid, v.ov);
        if (v.ov || v.rst) begin
            chk($sformatf("out_se[%0d]", idx), out_se, v.se);
            chk($sformatf("out_m[%0d]", idx), out_m, v.m);
            chk($sformatf("out_n[%0d]", idx), out_n, v.n);
        end
    endtask

    initial begin
        //         rst  vld     a  b  c  d  ordy rdy     ov se     m  n
        tbl[0]  = '{1'b1, 4'hF, 1, 2, 3, 4, 1'b1, 4'b0000, 0, 2'd0, 0, 0};
        tbl[1]  = '{1'b1, 4'hF, 1, 2, 3, 4, 1'b1, 4'b0000, 0, 2'd0, 0, 0};
        tbl[2]  = '{1'b0, 4'hF, 1, 2, 3, 4, 1'b1, 4'b0011, 1, 2'd0, 1, 2};
        tbl[3]  = '{1'b0, 4'hF, 1, 2, 3, 4, 1'b1, 4'b0110, 1, 2'd1, 2, 3};
        tbl[4]  = '{1'b0, 4'hF, 1, 2, 3, 4, 1'b1, 4'b1100, 1, 2'd2, 3, 4};
        tbl[5]  = '{1'b0, 4'hF, 1, 2, 3, 4, 1'b1, 4'b1001, 1, 2'd3, 1, 4};
        tbl[6]  = '{1'b0, 4'hF, 1, 2, 3, 4, 1'b1, 4'b0011, 1, 2'd0, 1, 2};
        // only B and C valid
        tbl[7]  = '{1'b0, 4'h6, 1, 5, 9, 4, 1'b1, 4'b0110, 1, 2'd1, 5, 9};
        tbl[8]  = '{1'b0, 4'h6, 1, 5, 9, 4, 1'b1, 4'b0110, 1, 2'd1, 5, 9};
        tbl[9]  = '{1'b0, 4'h6, 1, 5, 9, 4, 1'b1, 4'b0110, 1, 2'd1, 5, 9};
        // stall three cycles, then reload on the release edge
        tbl[10] = '{1'b0, 4'hF, 1, 2, 3, 4, 1'b0, 4'b0000, 1, 2'd1, 5, 9};
        tbl[11] = '{1'b0, 4'hF, 1, 2, 3, 4, 1'b0, 4'b0000, 1, 2'd1, 5, 9};
        tbl[12] = '{1'b0, 4'hF, 1, 2, 3, 4, 1'b0, 4'b0000, 1, 2'd1, 5, 9};
        tbl[13] = '{1'b0, 4'hF, 1, 2, 3, 4, 1'b1, 4'b1100, 1, 2'd2, 3, 4};
        // drain to EMPTY, refill, then reset mid-transfer
        tbl[14] = '{1'b0, 4'h0, 1, 2, 3, 4, 1'b1, 4'b0000, 0, 2'd0, 0, 0};
        tbl[15] = '{1'b0, 4'h5, 1, 2, 3, 4, 1'b1, 4'b0000, 0, 2'd0, 0, 0};
        tbl[16] = '{1'b0, 4'hF, 1, 2, 3, 4, 1'b1, 4'b1001, 1, 2'd3, 1, 4};
        tbl[17] = '{1'b1, 4'hF, 1, 2, 3, 4, 1'b0, 4'b0000, 0, 2'd0, 0, 0};

        for (int i = 0; i < 18; i++) step(tbl[i], i);

        // A+C never pair; then B joins: AB from ptr=0, then BC from ptr=1.
        step('{1'b1, 4'h0, 1, 2, 3, 4, 1'b1, 4'b0000, 0, 2'd0, 0, 0}, 100);
        step('{1'b0, 4'h5, 7, 2, 8, 4, 1'b1, 4'b0000, 0, 2'd0, 0, 0}, 101);
        step('{1'b0, 4'h5, 7, 2, 8, 4, 1'b1, 4'b0000, 0, 2'd0, 0, 0}, 102);
        step('{1'b0, 4'h7, 7, 2, 8, 4, 1'b1, 4'b0011, 1, 2'd0, 7, 2}, 103);
        step('{1'b0, 4'h7, 7, 6, 8, 4, 1'b1, 4'b0110, 1, 2'd1, 6, 8}, 104);

`ifdef MUX_SCHED_STATS_EN
        step('{1'b1, 4'h0, 1, 2, 3, 4, 1'b1, 4'b0000, 0, 2'd0, 0, 0}, 200);
        for (int i = 0; i < 10; i++)
            step('{1'b0, 4'hC, 1, 2, 3, 4, 1'b1, 4'b1100, 1, 2'd2, 3, 4}, 201 + i);
        chk("stat_cd_sat", stat_cd, 7);
        chk("stat_ab", stat_ab, 0);
        chk("stat_bc", stat_bc, 0);
        chk("stat_ad", stat_ad, 0);
        step('{1'b1, 4'h0, 1, 2, 3, 4, 1'b1, 4'b0000, 0, 2'd0, 0, 0}, 220);
        chk("stat_cd_clr", stat_cd, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
